// File: rtl/uart_pkg.sv
// Shared definitions for the UART/ALU command sequencer: FSM state codes and default widths.
package uart_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int OP_W_DEF   = 6;

  typedef logic [2:0] state_t;

  localparam state_t GET_A   = 3'd0;
  localparam state_t GET_B   = 3'd1;
  localparam state_t GET_OP  = 3'd2;
  localparam state_t EXEC    = 3'd3;
  localparam state_t LATCH   = 3'd4;
  localparam state_t SEND    = 3'd5;
  localparam state_t WAIT_TX = 3'd6;

endpackage

// File: rtl/edge_det.sv
// Registered 0->1 detector: a level held high yields a single-cycle event.
module edge_det (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) prev <= 1'b0;
    else       prev <= sig;
  end

  assign rise = sig & ~prev;

endmodule

// File: rtl/uart_alu_sequencer.sv
// Collects A/B/opcode bytes from the UART receiver, runs them through the ALU and sends the result.
// Optional inter-byte timeout with sticky frame_err is built when RX_TIMEOUT_EN is defined.
module uart_alu_sequencer
  import uart_pkg::*;
#(
  parameter int DATA_W         = DATA_W_DEF,
  parameter int OP_W           = OP_W_DEF,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_done,
  input  logic [DATA_W-1:0] rx_data,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              tx_done,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_start,
  output logic              busy,
  output logic              frame_err
);

  state_t state, state_nxt;
  logic   rx_edge, tx_edge, timeout;

  edge_det u_rx_edge (.clk(clk), .reset(reset), .sig(rx_done), .rise(rx_edge));
  edge_det u_tx_edge (.clk(clk), .reset(reset), .sig(tx_done), .rise(tx_edge));

`ifdef RX_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] to_cnt;
  logic             mid_frame;

  assign mid_frame = (state == GET_B) || (state == GET_OP);
  assign timeout   = mid_frame && !rx_edge && (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                      to_cnt <= '0;
    else if (rx_edge || !mid_frame) to_cnt <= '0;
    else                            to_cnt <= to_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                              frame_err <= 1'b0;
    else if (timeout)                       frame_err <= 1'b1;
    else if (state == GET_A && rx_edge)     frame_err <= 1'b0;
  end
`else
  assign timeout   = 1'b0;
  assign frame_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= GET_A;
    else       state <= state_nxt;
  end

  // rx edges outside the three capture states fall through unused, so they are dropped
  always_comb begin
    state_nxt = state;
    case (state)
      GET_A:   if (rx_edge) state_nxt = GET_B;
      GET_B:   if (timeout) state_nxt = GET_A;
               else if (rx_edge) state_nxt = GET_OP;
      GET_OP:  if (timeout) state_nxt = GET_A;
               else if (rx_edge) state_nxt = EXEC;
      EXEC:    state_nxt = LATCH;
      LATCH:   state_nxt = SEND;
      SEND:    state_nxt = WAIT_TX;
      WAIT_TX: if (tx_edge) state_nxt = GET_A;
      default: state_nxt = GET_A;
    endcase
  end

  always_comb begin
    tx_start = 1'b0;
    if (state == SEND) tx_start = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_op  <= '0;
      tx_data <= '0;
      busy    <= 1'b0;
    end else begin
      case (state)
        GET_A: if (rx_edge) begin
          alu_a <= rx_data;
          busy  <= 1'b1;
        end
        GET_B: begin
          if (timeout)      busy  <= 1'b0;
          else if (rx_edge) alu_b <= rx_data;
        end
        GET_OP: begin
          if (timeout)      busy   <= 1'b0;
          else if (rx_edge) alu_op <= rx_data[OP_W-1:0];
        end
        LATCH:   tx_data <= alu_result;
        WAIT_TX: if (tx_edge) busy <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
